// File: rtl/ctrl_reg_bank.sv
// Multi-channel control register bank: per-channel CTRL / sticky STATUS / event COUNT
// plus a constant ID register, behind a simple single-cycle write / registered read bus.
module ctrl_reg_bank #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CTRL_WIDTH = 16,
    parameter int unsigned EVT_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'h0000_A55A
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic                           write_enable,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           read_enable,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           read_valid,
    output logic                           access_error,
    output logic [NUM_CH-1:0]              pipe_enable,
    output logic [NUM_CH*CTRL_WIDTH-1:0]   ctrl_out,
    input  logic [NUM_CH*EVT_WIDTH-1:0]    event_in,
    output logic                           irq
);

    localparam int unsigned CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned ST_WIDTH = EVT_WIDTH + 1;
    localparam logic [CTRL_WIDTH-1:0] CLEAR_BIT = CTRL_WIDTH'(2);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_COUNT  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_t;

    logic [CTRL_WIDTH-1:0] ctrl        [NUM_CH];
    logic [ST_WIDTH-1:0]   status      [NUM_CH];
    logic [DATA_WIDTH-1:0] count       [NUM_CH];
    logic [ST_WIDTH-1:0]   status_next [NUM_CH];

    logic                  in_range;
    logic                  is_id;
    reg_sel_t              reg_sel;
    logic [CH_BITS-1:0]    ch_sel;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rd_illegal;
    logic                  wr_illegal;
    logic [NUM_CH-1:0]     wr_ctrl;
    logic [NUM_CH-1:0]     wr_status;
    logic [NUM_CH-1:0]     cnt_clear;
    logic [NUM_CH-1:0]     cnt_wrap;
    logic [NUM_CH-1:0]     irq_terms;

    always_comb begin
        in_range = address < ADDR_WIDTH'(4 * NUM_CH);
        is_id    = address == ADDR_WIDTH'(4 * NUM_CH);
        reg_sel  = reg_sel_t'(address[1:0]);
        ch_sel   = address[2 +: CH_BITS];
    end

    // Read mux samples current state, so a same-cycle write is not visible to the read.
    always_comb begin
        rd_value   = '0;
        rd_illegal = 1'b1;
        if (in_range) begin
            case (reg_sel)
                REG_CTRL: begin
                    rd_value   = DATA_WIDTH'(ctrl[ch_sel]);
                    rd_illegal = 1'b0;
                end
                REG_STATUS: begin
                    rd_value   = DATA_WIDTH'(status[ch_sel]);
                    rd_illegal = 1'b0;
                end
                REG_COUNT: begin
                    rd_value   = count[ch_sel];
                    rd_illegal = 1'b0;
                end
                default: begin
                    rd_value   = '0;
                    rd_illegal = 1'b1;
                end
            endcase
        end else if (is_id) begin
            rd_value   = ID_VALUE;
            rd_illegal = 1'b0;
        end
        wr_illegal = !(in_range && (reg_sel == REG_CTRL || reg_sel == REG_STATUS));
    end

    always_comb begin
        wr_ctrl     = '0;
        wr_status   = '0;
        cnt_clear   = '0;
        cnt_wrap    = '0;
        irq_terms   = '0;
        pipe_enable = '0;
        ctrl_out    = '0;
        status_next = '{default: '0};
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            wr_ctrl[ch]   = write_enable && in_range && ch_sel == CH_BITS'(ch) && reg_sel == REG_CTRL;
            wr_status[ch] = write_enable && in_range && ch_sel == CH_BITS'(ch) && reg_sel == REG_STATUS;
            cnt_clear[ch] = wr_ctrl[ch] && write_data[1];
            cnt_wrap[ch]  = !cnt_clear[ch] && ctrl[ch][0] && (count[ch] == '1);
            // Set terms are OR'd after the W1C mask so a coincident set wins.
            status_next[ch] = (status[ch] & ~(wr_status[ch] ? write_data[ST_WIDTH-1:0] : '0))
                            | {cnt_wrap[ch], event_in[ch*EVT_WIDTH +: EVT_WIDTH]};
            irq_terms[ch]   = ctrl[ch][2] && (|status[ch]);
            pipe_enable[ch] = ctrl[ch][0];
            ctrl_out[ch*CTRL_WIDTH +: CTRL_WIDTH] = ctrl[ch];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                ctrl[ch]   <= '0;
                status[ch] <= '0;
                count[ch]  <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                if (wr_ctrl[ch]) begin
                    ctrl[ch] <= write_data[CTRL_WIDTH-1:0] & ~CLEAR_BIT;
                end
                if (cnt_clear[ch]) begin
                    count[ch] <= '0;
                end else if (ctrl[ch][0]) begin
                    count[ch] <= count[ch] + DATA_WIDTH'(1);
                end
                status[ch] <= status_next[ch];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data    <= '0;
            read_valid   <= 1'b0;
            access_error <= 1'b0;
            irq          <= 1'b0;
        end else begin
            read_valid   <= read_enable;
            if (read_enable) begin
                read_data <= rd_value;
            end
            access_error <= (write_enable && wr_illegal) || (read_enable && rd_illegal);
            irq          <= |irq_terms;
        end
    end

endmodule

// File: doc/ctrl_reg_bank.md
Name: ctrl_reg_bank

Overview:
- Parametrised multi-channel successor to the single-register control block.
- Provides NUM_CH identical channel register sets (control, sticky status, event counter) plus a global ID register behind one simple W/R bus.
- Reads are registered and return a read_valid strobe.
- Sits between the configuration master and the engine pipelines. Drives per-channel pipe enables, per-channel control fields and a combined interrupt.

Parameters:
- ADDR_WIDTH, 8, bus address width.
- DATA_WIDTH, 32, bus data width; also the counter width.
- NUM_CH, 4, number of channels (1..16).
- CTRL_WIDTH, 16, stored control bits per channel (4 <= CTRL_WIDTH <= DATA_WIDTH).
- EVT_WIDTH, 4, hardware event inputs per channel (EVT_WIDTH < DATA_WIDTH).
- ID_VALUE, 32'h0000_A55A, constant returned by the ID register.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-low reset
- address  in  ADDR_WIDTH  word address
- write_enable  in  1  write strobe, single cycle
- write_data  in  DATA_WIDTH  write data
- read_enable  in  1  read strobe, single cycle
- read_data  out  DATA_WIDTH  registered read data
- read_valid  out  1  read_data valid, one cycle
- access_error  out  1  one-cycle pulse on an illegal access
- pipe_enable  out  NUM_CH  bit ch = CTRL[ch][0]
- ctrl_out  out  NUM_CH*CTRL_WIDTH  stored CTRL fields, channel 0 in LSBs
- event_in  in  NUM_CH*EVT_WIDTH  level-sampled event inputs
- irq  out  1  registered combined interrupt

Behaviour:
- Reset is asynchronous, active-low; clock is clock. On reset every register is 0, and read_data, read_valid, access_error, pipe_enable, ctrl_out and irq are all 0.
- Address map: channel ch occupies addresses 4*ch+0..3.
  - +0 CTRL: RW. Bit0 = pipe enable. Bit1 = counter clear, self-clearing, always reads 0. Bit2 = irq enable. Bits above 2 are plain storage. Bits >= CTRL_WIDTH read 0.
  - +1 STATUS: W1C. Bits [EVT_WIDTH-1:0] are sticky events. Bit EVT_WIDTH = counter overflow.
  - +2 COUNT: RO.
  - +3 reserved.
- Address 4*NUM_CH is the RO ID register. All other addresses are unmapped.
- Writes take effect on the clock edge where write_enable=1.
- Write to a RO, reserved or unmapped address: state unchanged; access_error=1 on the next cycle.
- Reads: read_enable at edge N gives read_data/read_valid=1 valid for the cycle after N. read_valid is 0 otherwise, and read_data holds its last value.
  - Read of reserved or unmapped address: read_data=0, read_valid=1, access_error=1 in the same cycle.
- Read and write in the same cycle, same address: the read returns the pre-write value. If both accesses are illegal, access_error is a single pulse.
- Counter:
  - Increments by 1 each cycle while CTRL bit0=1.
  - Writing CTRL with bit1=1 clears it to 0 at that edge, and clear overrides increment.
  - At all-ones it wraps to 0 and sets STATUS overflow at the same edge.
- STATUS bit i is set at any edge where event_in[ch*EVT_WIDTH+i]=1.
  - Writing 1 clears the bit; writing 0 leaves it unchanged.
  - If a set and a clear hit the same bit at the same edge, set wins.
- irq is registered: irq = OR over ch of (CTRL[ch] bit2 AND |STATUS[ch]). It rises one cycle after the status bit sets and falls one cycle after the clear.
- Reset asserted mid-operation: all state clears immediately, including any read in flight, so no read_valid is issued for it.

Test Plan:
- Reset, then read ID at address 4*NUM_CH (=16) -> one cycle later read_valid=1, read_data=32'h0000_A55A, access_error=0.
- Write 32'h0000_0005 to CTRL ch2 (address 8) -> pipe_enable=4'b0100, ctrl_out[47:32]=16'h0005. Wait 10 cycles, then read address 10 -> COUNT = 10 ±1 per documented timing. Write CTRL=32'h3 -> COUNT=0 next cycle, CTRL reads back 32'h1.
- Pulse event_in[5] (ch1 bit1) for one cycle with CTRL ch1 bit2=1 -> STATUS ch1 reads 32'h2, irq=1. Write 32'h2 to address 5 -> STATUS=0, irq=0. Repeat with a set and clear on the same edge -> STATUS stays 32'h2.
- Force COUNT ch0 near wrap (DATA_WIDTH=8 build, enable and run 256 cycles) -> COUNT wraps 8'hFF->8'h00, STATUS ch0 bit4=1.
- Write to address 2 (COUNT), write to 3, read address 200 -> each gives a one-cycle access_error. The read returns read_data=0 with read_valid=1. Register contents are unchanged.
- Assert reset while read_enable is issued and with counters running -> all outputs 0 immediately, no read_valid afterwards, COUNT=0 after release.
